// File: rtl/rst_sequencer.sv
// Board reset controller: merges debounced reset requests and PLL lock loss into
// staged, ordered reset releases, with a sticky record of what caused each reset.

module rst_seq_src #(
  parameter int DEBOUNCE = 4,
  parameter bit ACT_LOW  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic accepted
);
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Polarity is normalised ahead of the synchroniser so a cleared FF always means idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], raw ^ ACT_LOW};
      if (!sync[1])                   cnt <= '0;
      else if (cnt != CW'(DEBOUNCE))  cnt <= cnt + 1'b1;
    end
  end

  assign accepted = (cnt == CW'(DEBOUNCE));
endmodule

module rst_sequencer #(
  parameter int                 NUM_SRC     = 2,
  parameter int                 NUM_OUT     = 2,
  parameter logic [NUM_SRC-1:0] SRC_ACT_LOW = 2'b01,
  parameter int                 DEBOUNCE    = 4,
  parameter int                 HOLD_CYCLES = 3,
  parameter int                 STAGGER     = 4,
  parameter bit                 LOCK_EN     = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_SRC-1:0] i_src,
  input  logic               i_lock,
  input  logic               i_cause_clr,
  output logic [NUM_OUT-1:0] o_rst,
  output logic               o_ready,
  output logic [NUM_SRC:0]   o_cause
);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int SW = (STAGGER > 1)     ? $clog2(STAGGER)     : 1;
  localparam int IW = (NUM_OUT > 1)     ? $clog2(NUM_OUT)     : 1;

  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_t;

  logic [NUM_SRC-1:0] accepted;
  logic [1:0]         lk_sync;
  logic               lock_req;
  logic [NUM_SRC:0]   set;
  logic               req;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] stg_cnt;
  logic [IW-1:0] idx;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    rst_seq_src #(
      .DEBOUNCE (DEBOUNCE),
      .ACT_LOW  (SRC_ACT_LOW[g])
    ) u_src (
      .clk      (i_clk),
      .rst      (i_rst),
      .raw      (i_src[g]),
      .accepted (accepted[g])
    );
  end

  // Lock is synchronised as "lock lost" so the cleared synchroniser reads as locked.
  always_ff @(posedge i_clk) begin
    if (i_rst) lk_sync <= '0;
    else       lk_sync <= {lk_sync[0], ~i_lock};
  end

  assign lock_req = LOCK_EN && lk_sync[1];
  assign set      = {lock_req, accepted};
  assign req      = |set;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_ASSERT;
      o_rst    <= '1;
      o_ready  <= 1'b0;
      o_cause  <= '0;
      hold_cnt <= '0;
      stg_cnt  <= '0;
      idx      <= '0;
    end else begin
      o_cause <= (i_cause_clr ? '0 : o_cause) | set;
      if (req) begin
        state    <= ST_ASSERT;
        o_rst    <= '1;
        o_ready  <= 1'b0;
        hold_cnt <= '0;
        stg_cnt  <= '0;
        idx      <= '0;
      end else begin
        case (state)
          ST_ASSERT: begin
            if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
              state    <= ST_RELEASE;
              o_rst    <= o_rst << 1;
              hold_cnt <= '0;
              stg_cnt  <= '0;
              idx      <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_RELEASE: begin
            // Outputs are released LSB first, so shifting in a zero drops the next one.
            if (idx == IW'(NUM_OUT - 1)) begin
              state   <= ST_RUN;
              o_ready <= 1'b1;
            end else if (stg_cnt == SW'(STAGGER - 1)) begin
              stg_cnt <= '0;
              idx     <= idx + 1'b1;
              o_rst   <= o_rst << 1;
            end else begin
              stg_cnt <= stg_cnt + 1'b1;
            end
          end
          ST_RUN: begin
            o_rst   <= '0;
            o_ready <= 1'b1;
          end
          default: state <= ST_ASSERT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed stimulus with time-stamped expectations held in a
// scoreboard queue, plus per-cycle monotonicity and ready checks on three configurations.

module tb_rst_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic       rst_a, lock_a, clr_a, rdy_a;
  logic [1:0] src_a, orst_a;
  logic [2:0] cause_a;
  logic       rst_b, lock_b, clr_b, rdy_b;
  logic [1:0] src_b;
  logic [3:0] orst_b;
  logic [2:0] cause_b;
  logic       rst_c, lock_c, clr_c, rdy_c;
  logic [1:0] src_c;
  logic [0:0] orst_c;
  logic [2:0] cause_c;

  rst_sequencer dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_src(src_a), .i_lock(lock_a), .i_cause_clr(clr_a),
    .o_rst(orst_a), .o_ready(rdy_a), .o_cause(cause_a));

  rst_sequencer #(.NUM_OUT(4), .DEBOUNCE(1), .HOLD_CYCLES(1), .STAGGER(1)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_src(src_b), .i_lock(lock_b), .i_cause_clr(clr_b),
    .o_rst(orst_b), .o_ready(rdy_b), .o_cause(cause_b));

  rst_sequencer #(.NUM_OUT(1), .DEBOUNCE(1), .HOLD_CYCLES(1), .STAGGER(1),
                  .LOCK_EN(1'b0)) dut_c (
    .i_clk(clk), .i_rst(rst_c), .i_src(src_c), .i_lock(lock_c), .i_cause_clr(clr_c),
    .o_rst(orst_c), .o_ready(rdy_c), .o_cause(cause_c));

  typedef struct {
    int         cyc;
    int         inst;
    bit         kind;   // 0: o_rst/o_ready, 1: o_cause
    logic [3:0] rst;
    logic       rdy;
    logic [2:0] cause;
    string      tag;
  } exp_t;

  exp_t sb[$];

  function automatic logic [3:0] act_rst(int inst);
    if (inst == 0) return {2'b00, orst_a};
    if (inst == 1) return orst_b;
    return {3'b000, orst_c};
  endfunction

  function automatic logic act_rdy(int inst);
    if (inst == 0) return rdy_a;
    if (inst == 1) return rdy_b;
    return rdy_c;
  endfunction

  function automatic logic [2:0] act_cause(int inst);
    if (inst == 0) return cause_a;
    if (inst == 1) return cause_b;
    return cause_c;
  endfunction

  function automatic logic [3:0] full_mask(int inst);
    if (inst == 0) return 4'b0011;
    if (inst == 1) return 4'b1111;
    return 4'b0001;
  endfunction

  task automatic push_rst(int t, int inst, logic [3:0] r, logic rdy, string tag);
    exp_t e;
    e.cyc = t; e.inst = inst; e.kind = 1'b0; e.rst = r; e.rdy = rdy; e.cause = '0; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_cause(int t, int inst, logic [2:0] c, string tag);
    exp_t e;
    e.cyc = t; e.inst = inst; e.kind = 1'b1; e.rst = '0; e.rdy = 1'b0; e.cause = c; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_rng(int t0, int t1, int inst, logic [3:0] r, logic rdy, string tag);
    for (int t = t0; t <= t1; t++) push_rst(t, inst, r, rdy, tag);
  endtask

  // All outputs asserted from edge a; request gone from edge l; release timing by formula.
  task automatic push_seq(int inst, int a, int l, int nout, int hold, int stg, string tag);
    int entry, run, m;
    entry = l + hold - 1;
    run   = entry + (nout - 1) * stg + 1;
    m     = (1 << nout) - 1;
    for (int t = a; t <= run + 1; t++) begin
      int k, v;
      k = (t < entry) ? 0 : ((t - entry) / stg + 1);
      if (k > nout) k = nout;
      v = (m << k) & m;
      push_rst(t, inst, 4'(v), (t >= run), tag);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] prv [3] = '{4'b0011, 4'b1111, 4'b0001};

  always @(negedge clk) begin
    exp_t e;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        e = sb[i];
        sb.delete(i);
        checks++;
        if (e.cyc < cyc) begin
          errors++;
          $error("FAIL %s: inst %0d expectation for cyc %0d seen at cyc %0d", e.tag, e.inst, e.cyc, cyc);
        end else if (e.kind == 1'b0) begin
          assert (act_rst(e.inst) === e.rst) else begin
            errors++;
            $error("FAIL %s: inst %0d cyc %0d o_rst=%b expected %b", e.tag, e.inst, cyc, act_rst(e.inst), e.rst);
          end
          checks++;
          assert (act_rdy(e.inst) === e.rdy) else begin
            errors++;
            $error("FAIL %s: inst %0d cyc %0d o_ready=%b expected %b", e.tag, e.inst, cyc, act_rdy(e.inst), e.rdy);
          end
        end else begin
          assert (act_cause(e.inst) === e.cause) else begin
            errors++;
            $error("FAIL %s: inst %0d cyc %0d o_cause=%b expected %b", e.tag, e.inst, cyc, act_cause(e.inst), e.cause);
          end
        end
      end
    end
    for (int n = 0; n < 3; n++) begin
      logic [3:0] cur, m;
      cur = act_rst(n);
      m   = full_mask(n);
      if (cur !== m && prv[n] !== m) begin
        checks++;
        assert ((cur & ~prv[n]) === 4'b0000) else begin
          errors++;
          $error("FAIL monotonic: inst %0d cyc %0d o_rst=%b previous %b", n, cyc, cur, prv[n]);
        end
      end
      checks++;
      assert (act_rdy(n) === (cur === 4'b0000 && prv[n] === 4'b0000)) else begin
        errors++;
        $error("FAIL ready_track: inst %0d cyc %0d o_ready=%b o_rst=%b previous %b", n, cyc, act_rdy(n), cur, prv[n]);
      end
      prv[n] = cur;
    end
  end

  initial begin
    int x, e0;
    rst_a = 1'b1; src_a = 2'b01; lock_a = 1'b1; clr_a = 1'b0;
    rst_b = 1'b1; src_b = 2'b01; lock_b = 1'b1; clr_b = 1'b0;
    rst_c = 1'b1; src_c = 2'b01; lock_c = 1'b1; clr_c = 1'b0;

    tick(2);
    push_rst(cyc + 1, 0, 4'b0011, 1'b0, "reset_state");
    push_cause(cyc + 1, 0, 3'b000, "reset_cause");
    tick(1);

    // power-up release
    rst_a = 1'b0;
    push_seq(0, cyc + 1, cyc + 1, 2, 3, 4, "power_up");
    push_cause(cyc + 10, 0, 3'b000, "power_up_cause");
    tick(12);

    // button glitch shorter than debounce
    src_a[0] = 1'b0;
    push_rng(cyc + 1, cyc + 10, 0, 4'b0000, 1'b1, "glitch");
    push_cause(cyc + 10, 0, 3'b000, "glitch_cause");
    tick(3); src_a[0] = 1'b1; tick(10);

    // button held 10 cycles
    e0 = cyc + 1;
    src_a[0] = 1'b0;
    push_rng(e0, e0 + 5, 0, 4'b0000, 1'b1, "btn_latency");
    push_seq(0, e0 + 6, e0 + 13, 2, 3, 4, "btn_seq");
    push_cause(e0 + 6, 0, 3'b001, "btn_cause");
    tick(10); src_a[0] = 1'b1; tick(14);

    clr_a = 1'b1;
    push_cause(cyc + 1, 0, 3'b000, "cause_clr");
    tick(1); clr_a = 1'b0; tick(2);

    // single-cycle lock loss
    x = cyc + 1;
    lock_a = 1'b0;
    push_rng(x, x + 1, 0, 4'b0000, 1'b1, "lock_latency");
    push_seq(0, x + 2, x + 3, 2, 3, 4, "lock_seq");
    push_cause(x + 1, 0, 3'b000, "lock_cause_pre");
    push_cause(x + 2, 0, 3'b100, "lock_cause");
    tick(1); lock_a = 1'b1; tick(12);

    clr_a = 1'b1;
    push_cause(cyc + 1, 0, 3'b000, "cause_clr2");
    tick(1); clr_a = 1'b0; tick(2);

    // lock loss, then src1 arrives while o_rst=10
    x = cyc + 1;
    lock_a = 1'b0;
    push_rng(x + 2, x + 4, 0, 4'b0011, 1'b0, "mid_assert");
    push_rng(x + 5, x + 6, 0, 4'b0010, 1'b0, "mid_release");
    push_seq(0, x + 7, x + 9, 2, 3, 4, "mid_restart");
    push_cause(x + 6, 0, 3'b100, "mid_cause_lock");
    push_cause(x + 7, 0, 3'b110, "mid_cause_src1");
    tick(1); lock_a = 1'b1; src_a[1] = 1'b1;
    tick(5); src_a[1] = 1'b0; tick(12);

    // clear in the same cycle the button is first accepted
    e0 = cyc + 1;
    src_a[0] = 1'b0;
    push_cause(e0 + 5, 0, 3'b110, "setclr_pre");
    push_cause(e0 + 6, 0, 3'b001, "set_beats_clr");
    push_cause(e0 + 7, 0, 3'b001, "set_sticky");
    push_seq(0, e0 + 6, e0 + 13, 2, 3, 4, "setclr_seq");
    tick(6); clr_a = 1'b1; tick(1); clr_a = 1'b0;
    tick(3); src_a[0] = 1'b1; tick(13);

    // NUM_OUT=4, fastest timing
    rst_b = 1'b0;
    push_seq(1, cyc + 1, cyc + 1, 4, 1, 1, "b_power_up");
    tick(8);
    e0 = cyc + 1;
    src_b[0] = 1'b0;
    push_rng(e0, e0 + 2, 1, 4'b0000, 1'b1, "b_latency");
    push_seq(1, e0 + 3, e0 + 4, 4, 1, 1, "b_seq");
    push_cause(e0 + 3, 1, 3'b001, "b_cause");
    tick(1); src_b[0] = 1'b1; tick(12);

    // NUM_OUT=1, lock ignored
    rst_c = 1'b0;
    push_rst(cyc + 1, 2, 4'b0000, 1'b0, "c_release");
    push_rst(cyc + 2, 2, 4'b0000, 1'b1, "c_run");
    tick(4);
    lock_c = 1'b0;
    push_rng(cyc + 1, cyc + 8, 2, 4'b0000, 1'b1, "c_lock_ignored");
    push_cause(cyc + 8, 2, 3'b000, "c_lock_cause");
    tick(4); lock_c = 1'b1; tick(6);
    e0 = cyc + 1;
    src_c[1] = 1'b1;
    push_rng(e0, e0 + 2, 2, 4'b0000, 1'b1, "c_latency");
    push_seq(2, e0 + 3, e0 + 5, 1, 1, 1, "c_seq");
    push_cause(e0 + 3, 2, 3'b010, "c_cause");
    tick(2); src_c[1] = 1'b0; tick(10);

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain: %0d expectations never compared, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
